// File: rtl/tf_quantization_ctrl_pkg.sv
// Shared definitions for the TF-quantization offset sequencer: FSM encoding
// and default datapath widths, reused by the layer top.
package tf_quantization_ctrl_pkg;

  localparam int unsigned DEF_NEURON_ACTIV_BIT_WIDTH     = 8;
  localparam int unsigned DEF_QUAN_WEIGHT_ZERO_BIT_WIDTH = 8;
  localparam int unsigned DEF_QUAN_SCALE_BIT_WIDTH       = 24;
  localparam int unsigned DEF_STAGE_LEN_BIT_WIDTH        = 16;
  localparam int unsigned DEF_NUM_STAGE_BIT_WIDTH        = 12;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_FLUSH = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } tq_state_e;

endpackage

// File: rtl/tf_quantization_ctrl.sv
// Sequencer for the TF-quantization offset datapath. Groups the activation
// stream into stages, issues a stage_finish beat at the first element of
// every stage (and a trailing flush beat), and returns one registered
// quan_scale result per closed stage, tagged with its stage index.
module tf_quantization_ctrl
  import tf_quantization_ctrl_pkg::*;
#(
  parameter int unsigned NEURON_ACTIV_BIT_WIDTH     = DEF_NEURON_ACTIV_BIT_WIDTH,
  parameter int unsigned QUAN_WEIGHT_ZERO_BIT_WIDTH = DEF_QUAN_WEIGHT_ZERO_BIT_WIDTH,
  parameter int unsigned QUAN_SCALE_BIT_WIDTH       = DEF_QUAN_SCALE_BIT_WIDTH,
  parameter int unsigned STAGE_LEN_BIT_WIDTH        = DEF_STAGE_LEN_BIT_WIDTH,
  parameter int unsigned NUM_STAGE_BIT_WIDTH        = DEF_NUM_STAGE_BIT_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  layer_reset_n,
  input  logic                                  start_i,
  input  logic [STAGE_LEN_BIT_WIDTH-1:0]        cfg_stage_len_i,
  input  logic [NUM_STAGE_BIT_WIDTH-1:0]        cfg_num_stages_i,
  input  logic [QUAN_WEIGHT_ZERO_BIT_WIDTH-1:0] cfg_weight_zero_i,
  input  logic                                  act_valid_i,
  input  logic [NEURON_ACTIV_BIT_WIDTH-1:0]     act_data_i,
  output logic                                  act_ready_o,
  output logic                                  tq_en_o,
  output logic                                  tq_stage_finish_o,
  output logic [NEURON_ACTIV_BIT_WIDTH-1:0]     tq_activation_o,
  output logic [QUAN_WEIGHT_ZERO_BIT_WIDTH-1:0] tq_weight_zero_o,
  input  logic [QUAN_SCALE_BIT_WIDTH-1:0]       quan_scale_i,
  output logic                                  scale_valid_o,
  output logic [QUAN_SCALE_BIT_WIDTH-1:0]       scale_o,
  output logic [NUM_STAGE_BIT_WIDTH-1:0]        scale_idx_o,
  output logic                                  busy_o,
  output logic                                  done_o
);

  tq_state_e                             state_q;
  logic [STAGE_LEN_BIT_WIDTH-1:0]        elem_cnt_q, elem_cnt_d;
  logic [NUM_STAGE_BIT_WIDTH-1:0]        stage_cnt_q, stage_cnt_d;
  logic [STAGE_LEN_BIT_WIDTH-1:0]        cfg_len_q;
  logic [NUM_STAGE_BIT_WIDTH-1:0]        cfg_stages_q;
  logic [QUAN_WEIGHT_ZERO_BIT_WIDTH-1:0] cfg_zero_q;
  logic                                  pend_q;
  logic [NUM_STAGE_BIT_WIDTH-1:0]        pend_idx_q;
  logic                                  scale_valid_q;
  logic [QUAN_SCALE_BIT_WIDTH-1:0]       scale_q;
  logic [NUM_STAGE_BIT_WIDTH-1:0]        scale_idx_q;
  logic                                  done_q;

  logic                                  in_run, in_flush, transfer;
  logic                                  first_elem, last_elem, last_stage;
  logic                                  finish_beat, closes_stage;
  logic [NUM_STAGE_BIT_WIDTH-1:0]        close_idx;

  assign in_run     = (state_q == ST_RUN);
  assign in_flush   = (state_q == ST_FLUSH);
  assign transfer   = in_run && act_valid_i;
  assign first_elem = (elem_cnt_q == '0);
  assign last_elem  = (elem_cnt_q == cfg_len_q - STAGE_LEN_BIT_WIDTH'(1));
  assign last_stage = (stage_cnt_q == cfg_stages_q - NUM_STAGE_BIT_WIDTH'(1));

  // The stage-0 finish only clears stale datapath state, so it closes nothing.
  // By FLUSH the stage counter has advanced to num_stages, so stage_cnt-1 is
  // the closed stage in both the RUN and FLUSH cases.
  assign finish_beat  = (transfer && first_elem) || in_flush;
  assign closes_stage = finish_beat && (in_flush || (stage_cnt_q != '0));
  assign close_idx    = stage_cnt_q - NUM_STAGE_BIT_WIDTH'(1);

  assign act_ready_o       = in_run;
  assign tq_en_o           = transfer || in_flush;
  assign tq_stage_finish_o = finish_beat;
  assign tq_activation_o   = in_run ? act_data_i : '0;
  assign tq_weight_zero_o  = cfg_zero_q;
  assign scale_valid_o     = scale_valid_q;
  assign scale_o           = scale_q;
  assign scale_idx_o       = scale_idx_q;
  assign busy_o            = (state_q != ST_IDLE);
  assign done_o            = done_q;

  // Element/stage counter advance on each accepted activation.
  always_comb begin
    elem_cnt_d  = elem_cnt_q;
    stage_cnt_d = stage_cnt_q;
    if (transfer) begin
      if (last_elem) begin
        elem_cnt_d  = '0;
        stage_cnt_d = stage_cnt_q + NUM_STAGE_BIT_WIDTH'(1);
      end else begin
        elem_cnt_d  = elem_cnt_q + STAGE_LEN_BIT_WIDTH'(1);
      end
    end
  end

  // Sequencer FSM, finish-to-result pending pipe and registered result outputs.
  always_ff @(posedge clk) begin
    if (!layer_reset_n) begin
      state_q       <= ST_IDLE;
      elem_cnt_q    <= '0;
      stage_cnt_q   <= '0;
      cfg_len_q     <= '0;
      cfg_stages_q  <= '0;
      cfg_zero_q    <= '0;
      pend_q        <= 1'b0;
      pend_idx_q    <= '0;
      scale_valid_q <= 1'b0;
      scale_q       <= '0;
      scale_idx_q   <= '0;
      done_q        <= 1'b0;
    end else begin
      // Datapath result for a finish in cycle t is on quan_scale_i in t+1.
      pend_q        <= closes_stage;
      if (closes_stage) pend_idx_q <= close_idx;
      scale_valid_q <= pend_q;
      if (pend_q) begin
        scale_q     <= quan_scale_i;
        scale_idx_q <= pend_idx_q;
      end
      done_q <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            cfg_len_q    <= cfg_stage_len_i;
            cfg_stages_q <= cfg_num_stages_i;
            cfg_zero_q   <= cfg_weight_zero_i;
            elem_cnt_q   <= '0;
            stage_cnt_q  <= '0;
            if ((cfg_stage_len_i == '0) || (cfg_num_stages_i == '0)) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          elem_cnt_q  <= elem_cnt_d;
          stage_cnt_q <= stage_cnt_d;
          if (transfer && last_elem && last_stage) state_q <= ST_FLUSH;
        end
        ST_FLUSH: state_q <= ST_DRAIN;
        ST_DRAIN: begin
          state_q <= ST_DONE;
          done_q  <= 1'b1;
        end
        ST_DONE:  state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tf_quantization_ctrl.sv
// Directed bench for tf_quantization_ctrl with a behavioural model of the
// offset datapath (running sum, result = sum * zero-point on stage_finish).
module tb_tf_quantization_ctrl;

  logic        clk = 1'b0;
  logic        layer_reset_n;
  logic        start_i;
  logic [15:0] cfg_stage_len_i;
  logic [11:0] cfg_num_stages_i;
  logic [7:0]  cfg_weight_zero_i;
  logic        act_valid_i;
  logic [7:0]  act_data_i;
  logic        act_ready_o, tq_en_o, tq_stage_finish_o;
  logic [7:0]  tq_activation_o, tq_weight_zero_o;
  logic [23:0] quan_scale_i;
  logic        scale_valid_o;
  logic [23:0] scale_o;
  logic [11:0] scale_idx_o;
  logic        busy_o, done_o;

  tf_quantization_ctrl #(
    .NEURON_ACTIV_BIT_WIDTH    (8),
    .QUAN_WEIGHT_ZERO_BIT_WIDTH(8),
    .QUAN_SCALE_BIT_WIDTH      (24),
    .STAGE_LEN_BIT_WIDTH       (16),
    .NUM_STAGE_BIT_WIDTH       (12)
  ) dut (
    .clk              (clk),
    .layer_reset_n    (layer_reset_n),
    .start_i          (start_i),
    .cfg_stage_len_i  (cfg_stage_len_i),
    .cfg_num_stages_i (cfg_num_stages_i),
    .cfg_weight_zero_i(cfg_weight_zero_i),
    .act_valid_i      (act_valid_i),
    .act_data_i       (act_data_i),
    .act_ready_o      (act_ready_o),
    .tq_en_o          (tq_en_o),
    .tq_stage_finish_o(tq_stage_finish_o),
    .tq_activation_o  (tq_activation_o),
    .tq_weight_zero_o (tq_weight_zero_o),
    .quan_scale_i     (quan_scale_i),
    .scale_valid_o    (scale_valid_o),
    .scale_o          (scale_o),
    .scale_idx_o      (scale_idx_o),
    .busy_o           (busy_o),
    .done_o           (done_o)
  );

  always #5 clk = ~clk;

  // Datapath model: no reset, so state survives layer resets.
  logic [23:0] dp_sum = '0;
  logic [23:0] dp_quan = '0;
  assign quan_scale_i = dp_quan;
  always @(posedge clk) begin
    if (tq_en_o) begin
      if (tq_stage_finish_o) begin
        dp_quan <= 24'(dp_sum * {16'd0, tq_weight_zero_o});
        dp_sum  <= {16'd0, tq_activation_o};
      end else begin
        dp_sum  <= dp_sum + {16'd0, tq_activation_o};
      end
    end
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor.
  int          sv_val[$];
  int          sv_idx[$];
  int          sv_cyc[$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          en_cnt = 0;
  int          en_bad = 0;
  always @(negedge clk) begin
    if (scale_valid_o) begin
      sv_val.push_back(int'(scale_o));
      sv_idx.push_back(int'(scale_idx_o));
      sv_cyc.push_back(int'(cyc));
    end
    if (done_o) begin
      done_cnt++;
      done_cyc = int'(cyc);
    end
    if (tq_en_o) en_cnt++;
    if (act_valid_i && act_ready_o && !tq_en_o) en_bad++;
    if (tq_en_o && !(act_valid_i && act_ready_o) &&
        !(tq_stage_finish_o && !act_ready_o && busy_o && tq_activation_o == 8'd0))
      en_bad++;
  end

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rec();
    sv_val.delete();
    sv_idx.delete();
    sv_cyc.delete();
    done_cnt = 0;
    done_cyc = 0;
    en_cnt   = 0;
    en_bad   = 0;
  endtask

  int start_cyc;
  task automatic do_start(input int len, input int stages, input int zero);
    start_i           = 1'b1;
    cfg_stage_len_i   = 16'(len);
    cfg_num_stages_i  = 12'(stages);
    cfg_weight_zero_i = 8'(zero);
    tick();
    start_cyc = int'(cyc);
    start_i   = 1'b0;
  endtask

  task automatic send_act(input int d, input bit gaps);
    int n;
    if (gaps) begin
      n = 0;
      while ($urandom_range(0, 1) == 1 && n < 3) begin
        act_valid_i = 1'b0;
        tick();
        n++;
      end
    end
    act_valid_i = 1'b1;
    act_data_i  = 8'(d);
    n = 0;
    while (!act_ready_o && n < 20) begin
      tick();
      n++;
    end
    if (!act_ready_o) check_eq("ready_timeout", 32'(act_ready_o), 32'd1);
    tick();
    act_valid_i = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && done_cnt == 0; i++) tick();
    repeat (3) tick();
    check_eq("done_count", 32'(done_cnt), 32'd1);
  endtask

  int exp_v[8];
  int exp_i[8];
  task automatic check_scales(input string tag, input int n);
    check_eq({tag, "_count"}, 32'(sv_val.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < sv_val.size()) begin
        check_eq({tag, "_val"}, 32'(sv_val[i]), 32'(exp_v[i]));
        check_eq({tag, "_idx"}, 32'(sv_idx[i]), 32'(exp_i[i]));
      end
    end
    if (n > 0 && sv_cyc.size() == n)
      check_eq({tag, "_done_not_early"}, 32'(done_cyc >= sv_cyc[n-1]), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    layer_reset_n     = 1'b0;
    start_i           = 1'b0;
    cfg_stage_len_i   = '0;
    cfg_num_stages_i  = '0;
    cfg_weight_zero_i = '0;
    act_valid_i       = 1'b0;
    act_data_i        = '0;
    repeat (2) tick();

    // Reset state.
    check_eq("rst_busy",  32'(busy_o), 32'd0);
    check_eq("rst_ready", 32'(act_ready_o), 32'd0);
    check_eq("rst_valid", 32'(scale_valid_o), 32'd0);
    check_eq("rst_scale", 32'(scale_o), 32'd0);
    check_eq("rst_idx",   32'(scale_idx_o), 32'd0);
    check_eq("rst_done",  32'(done_o), 32'd0);
    layer_reset_n = 1'b1;
    tick();

    // len=3 stages=2 zero=2, back-to-back: (1+2+3)*2=12, (4+5+6)*2=30.
    clear_rec();
    do_start(3, 2, 2);
    check_eq("t1_busy", 32'(busy_o), 32'd1);
    check_eq("t1_wz",   32'(tq_weight_zero_o), 32'd2);
    for (int a = 1; a <= 6; a++) send_act(a, 1'b0);
    wait_done();
    exp_v[0] = 12; exp_i[0] = 0;
    exp_v[1] = 30; exp_i[1] = 1;
    check_scales("t1", 2);
    check_eq("t1_en_cnt", 32'(en_cnt), 32'd7);
    check_eq("t1_en_bad", 32'(en_bad), 32'd0);
    check_eq("t1_idle", 32'(busy_o), 32'd0);

    // Same layer with random valid gaps.
    clear_rec();
    do_start(3, 2, 2);
    for (int a = 1; a <= 6; a++) send_act(a, 1'b1);
    wait_done();
    check_scales("t2", 2);
    check_eq("t2_en_cnt", 32'(en_cnt), 32'd7);
    check_eq("t2_en_bad", 32'(en_bad), 32'd0);

    // len=1 stages=4 zero=3: 15,0,21,765 on consecutive cycles.
    clear_rec();
    do_start(1, 4, 3);
    send_act(5, 1'b0);
    send_act(0, 1'b0);
    send_act(7, 1'b0);
    send_act(255, 1'b0);
    wait_done();
    exp_v[0] = 15;  exp_i[0] = 0;
    exp_v[1] = 0;   exp_i[1] = 1;
    exp_v[2] = 21;  exp_i[2] = 2;
    exp_v[3] = 765; exp_i[3] = 3;
    check_scales("t3", 4);
    if (sv_cyc.size() == 4) begin
      for (int i = 1; i < 4; i++)
        check_eq("t3_consec", 32'(sv_cyc[i] - sv_cyc[0]), 32'(i));
      check_eq("t3_done_with_last", 32'(done_cyc), 32'(sv_cyc[3]));
    end

    // Zero-length layer: done the cycle after start, nothing issued.
    clear_rec();
    do_start(0, 5, 1);
    wait_done();
    check_eq("t4_done_cyc", 32'(done_cyc), 32'(start_cyc));
    check_eq("t4_en_cnt",   32'(en_cnt), 32'd0);
    check_eq("t4_scales",   32'(sv_val.size()), 32'd0);

    // Start during RUN is ignored: cfg stays len=2 stages=1 zero=1.
    clear_rec();
    do_start(2, 1, 1);
    send_act(3, 1'b0);
    do_start(5, 3, 9);
    check_eq("t4_wz_kept", 32'(tq_weight_zero_o), 32'd1);
    send_act(4, 1'b0);
    wait_done();
    exp_v[0] = 7; exp_i[0] = 0;
    check_scales("t4b", 1);

    // Reset mid-stage 1 leaving datapath sum 100; stage 0 result (60) issued.
    clear_rec();
    do_start(3, 3, 1);
    send_act(10, 1'b0);
    send_act(20, 1'b0);
    send_act(30, 1'b0);
    send_act(50, 1'b0);
    send_act(50, 1'b0);
    repeat (3) tick();
    check_eq("t5_pre_cnt", 32'(sv_val.size()), 32'd1);
    if (sv_val.size() >= 1) check_eq("t5_pre_val", 32'(sv_val[0]), 32'd60);
    layer_reset_n = 1'b0;
    tick();
    check_eq("t5_rst_busy",  32'(busy_o), 32'd0);
    check_eq("t5_rst_ready", 32'(act_ready_o), 32'd0);
    check_eq("t5_rst_en",    32'(tq_en_o), 32'd0);
    check_eq("t5_rst_wz",    32'(tq_weight_zero_o), 32'd0);
    check_eq("t5_rst_scale", 32'(scale_o), 32'd0);
    check_eq("t5_rst_idx",   32'(scale_idx_o), 32'd0);
    layer_reset_n = 1'b1;
    repeat (4) tick();
    check_eq("t5_no_more", 32'(sv_val.size()), 32'd1);
    check_eq("t5_no_done", 32'(done_cnt), 32'd0);

    // New layer after stale sum 100: (3+4)*4=28, stale 400 discarded.
    clear_rec();
    do_start(2, 1, 4);
    send_act(3, 1'b0);
    send_act(4, 1'b0);
    wait_done();
    exp_v[0] = 28; exp_i[0] = 0;
    check_scales("t6", 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
